// File: rtl/apb_wait_completer.sv
// APB4 completer with a DEPTH-word byte-strobed register bank, fixed WAIT wait states,
// PSLVERR on misaligned/out-of-range/read-only accesses and a committed-write counter (WCNT).
module apb_wait_completer #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int DEPTH = 16,
  parameter int WAIT  = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR-1:0]   paddr,
  input  logic              pwrite,
  input  logic [DATA-1:0]   pwdata,
  input  logic [DATA/8-1:0] pstrb,
  input  logic              psel,
  input  logic              penable,
  output logic [DATA-1:0]   prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA / 8;
  localparam logic [ADDR-1:0] WCNT_ADDR = ADDR'(DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            enter_ready;

  logic [IW-1:0]   l_idx;
  logic            l_wcnt, l_write, l_err;
  logic [DATA-1:0] l_wdata;
  logic [NB-1:0]   l_strb;

  logic [DATA-1:0] bank [DEPTH];
  logic [31:0]     wcnt;

  logic            setup, live_err, live_wcnt;
  logic [IW-1:0]   live_idx;
  logic [IW-1:0]   src_idx;
  logic            src_wcnt, src_write, src_err;
  logic [DATA-1:0] rdval;
  logic            pready_nxt, pslverr_nxt;
  logic [DATA-1:0] prdata_nxt;
  logic            commit;

  assign setup     = psel & ~penable;
  assign live_wcnt = (paddr == WCNT_ADDR);
  assign live_idx  = paddr[2 +: IW];
  assign live_err  = (paddr[1:0] != 2'b00) | (paddr > WCNT_ADDR) | (pwrite & live_wcnt);
  assign commit    = (state == S_READY) & l_write & ~l_err;

  // State register; the registered outputs are loaded from the output logic below
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      l_idx   <= '0;
      l_wcnt  <= 1'b0;
      l_write <= 1'b0;
      l_err   <= 1'b0;
      l_wdata <= '0;
      l_strb  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      prdata  <= prdata_nxt;
      if (state == S_IDLE && setup) begin
        l_idx   <= live_idx;
        l_wcnt  <= live_wcnt;
        l_write <= pwrite;
        l_err   <= live_err;
        l_wdata <= pwdata;
        l_strb  <= pstrb;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    enter_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (setup) begin
          if (WAIT == 0) begin
            state_nxt   = S_READY;
            enter_ready = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT - 1);
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt   = S_READY;
          enter_ready = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_READY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With WAIT=0 the READY entry happens on the setup edge, so the live request is used
  always_comb begin
    src_idx     = (state == S_IDLE) ? live_idx  : l_idx;
    src_wcnt    = (state == S_IDLE) ? live_wcnt : l_wcnt;
    src_write   = (state == S_IDLE) ? pwrite    : l_write;
    src_err     = (state == S_IDLE) ? live_err  : l_err;
    if (src_write || src_err) rdval = '0;
    else if (src_wcnt)        rdval = DATA'(wcnt);
    else                      rdval = bank[src_idx];
    pready_nxt  = enter_ready;
    pslverr_nxt = enter_ready & src_err;
    prdata_nxt  = enter_ready ? rdval : '0;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
      wcnt <= '0;
    end else if (commit) begin
      for (int unsigned k = 0; k < NB; k++)
        if (l_strb[k]) bank[l_idx][8*k +: 8] <= l_wdata[8*k +: 8];
      wcnt <= wcnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_apb_wait_completer.sv
// Directed bench for apb_wait_completer: a WAIT=2 instance (a) and a WAIT=0 instance (b).
module tb_apb_wait_completer;

  logic        clk = 1'b0;
  logic        preset;
  logic [31:0] paddr_a, pwdata_a, prdata_a, paddr_b, pwdata_b, prdata_b;
  logic [3:0]  pstrb_a, pstrb_b;
  logic        pwrite_a, psel_a, penable_a, pready_a, pslverr_a;
  logic        pwrite_b, psel_b, penable_b, pready_b, pslverr_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  apb_wait_completer #(.DATA(32), .ADDR(32), .DEPTH(16), .WAIT(2)) u_dut (
    .pclk(clk), .preset(preset), .paddr(paddr_a), .pwrite(pwrite_a), .pwdata(pwdata_a),
    .pstrb(pstrb_a), .psel(psel_a), .penable(penable_a), .prdata(prdata_a),
    .pready(pready_a), .pslverr(pslverr_a));

  apb_wait_completer #(.DATA(32), .ADDR(32), .DEPTH(16), .WAIT(0)) u_dut0 (
    .pclk(clk), .preset(preset), .paddr(paddr_b), .pwrite(pwrite_b), .pwdata(pwdata_b),
    .pstrb(pstrb_b), .psel(psel_b), .penable(penable_b), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w0, input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (w0) begin
      psel_b = s; penable_b = e; pwrite_b = w; paddr_b = a; pwdata_b = d; pstrb_b = st;
    end else begin
      psel_a = s; penable_a = e; pwrite_a = w; paddr_a = a; pwdata_a = d; pstrb_a = st;
    end
  endtask

  function automatic logic rdy(input bit w0);
    return w0 ? pready_b : pready_a;
  endfunction
  function automatic logic err(input bit w0);
    return w0 ? pslverr_b : pslverr_a;
  endfunction
  function automatic logic [31:0] rdat(input bit w0);
    return w0 ? prdata_b : prdata_a;
  endfunction

  // Called #1 after a rising edge; returns #1 after the completion edge with the bus still selected
  task automatic xfer(input bit w0, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int nw, input logic [31:0] erd,
                      input logic eerr, input string tag);
    drive(w0, 1'b1, 1'b0, wr, addr, wd, st);
    @(posedge clk); #1;
    drive(w0, 1'b1, 1'b1, wr, addr, wd, st);
    for (int c = 0; c <= nw; c++) begin
      @(negedge clk);
      if (c < nw) begin
        chk({tag, ":wait_pready"}, 32'(rdy(w0)), 32'd0);
      end else begin
        chk({tag, ":pready"}, 32'(rdy(w0)), 32'd1);
        chk({tag, ":pslverr"}, 32'(err(w0)), 32'(eerr));
        chk({tag, ":prdata"}, rdat(w0), erd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input bit w0, input string tag);
    drive(w0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk({tag, ":idle_pready"}, 32'(rdy(w0)), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] vals [4];

  initial begin
    vals[0] = 32'h0BAD_F00D; vals[1] = 32'h1234_5678;
    vals[2] = 32'hFFFF_0000; vals[3] = 32'h8000_0001;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    preset = 1'b1;
    #1;
    chk("rst_pready_a", 32'(pready_a), 32'd0);
    chk("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    chk("rst_prdata_a", prdata_a, 32'd0);
    chk("rst_pready_b", 32'(pready_b), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    preset = 1'b0;
    idle(1'b0, "post_rst");

    // Basic read, strobed writes, WCNT
    xfer(1'b0, 1'b0, 32'h08, 32'd0, 4'h0, 2, 32'd0, 1'b0, "rd08");
    idle(1'b0, "rd08");
    xfer(1'b0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 2, 32'd0, 1'b0, "wr04_full");
    xfer(1'b0, 1'b1, 32'h04, 32'h0000_0011, 4'h1, 2, 32'd0, 1'b0, "wr04_lane0");
    xfer(1'b0, 1'b0, 32'h04, 32'd0, 4'h0, 2, 32'hDEAD_BE11, 1'b0, "rd04");
    xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'h0, 2, 32'd2, 1'b0, "rd_wcnt2");
    idle(1'b0, "after_wcnt");

    // Error responses leave state untouched
    xfer(1'b0, 1'b1, 32'h06, 32'h1111_1111, 4'hF, 2, 32'd0, 1'b1, "err_misalign");
    xfer(1'b0, 1'b1, 32'h44, 32'h2222_2222, 4'hF, 2, 32'd0, 1'b1, "err_range");
    xfer(1'b0, 1'b1, 32'h40, 32'h3333_3333, 4'hF, 2, 32'd0, 1'b1, "err_wcnt_wr");
    xfer(1'b0, 1'b0, 32'h80, 32'd0, 4'h0, 2, 32'd0, 1'b1, "err_rd80");
    xfer(1'b0, 1'b0, 32'h04, 32'd0, 4'h0, 2, 32'hDEAD_BE11, 1'b0, "rd04_after_err");
    xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'h0, 2, 32'd2, 1'b0, "rd_wcnt_after_err");
    idle(1'b0, "after_err");

    // Abort: psel dropped in the first wait cycle of a write
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("abort_wait_pready", 32'(pready_a), 32'd0);
    idle(1'b0, "abort1");
    idle(1'b0, "abort2");
    idle(1'b0, "abort3");
    xfer(1'b0, 1'b0, 32'h08, 32'd0, 4'h0, 2, 32'd0, 1'b0, "rd08_after_abort");
    xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'h0, 2, 32'd2, 1'b0, "wcnt_after_abort");
    xfer(1'b0, 1'b1, 32'h00, 32'h1234_5678, 4'hF, 2, 32'd0, 1'b0, "wr00");
    xfer(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, 2, 32'h1234_5678, 1'b0, "rd00");
    xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'h0, 2, 32'd3, 1'b0, "wcnt3");
    idle(1'b0, "pre_rst2");

    // Reset in the second wait cycle of a write
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'hA5A5_A5A5, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'hA5A5_A5A5, 4'hF);
    @(posedge clk); #1;
    preset = 1'b1;
    #1;
    chk("midrst_pready", 32'(pready_a), 32'd0);
    chk("midrst_pslverr", 32'(pslverr_a), 32'd0);
    chk("midrst_prdata", prdata_a, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    preset = 1'b0;
    idle(1'b0, "post_rst2_a");
    idle(1'b0, "post_rst2_b");
    xfer(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, 2, 32'd0, 1'b0, "rd00_after_rst");
    xfer(1'b0, 1'b0, 32'h04, 32'd0, 4'h0, 2, 32'd0, 1'b0, "rd04_after_rst");
    xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'h0, 2, 32'd0, 1'b0, "wcnt_after_rst");
    idle(1'b0, "end_a");

    // WAIT=0 instance: back-to-back writes then reads
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 1'b1, 32'(4 * i), vals[i], 4'hF, 0, 32'd0, 1'b0, $sformatf("w0_wr%0d", i));
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 1'b0, 32'(4 * i), 32'd0, 4'h0, 0, vals[i], 1'b0, $sformatf("w0_rd%0d", i));
    xfer(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 0, 32'd4, 1'b0, "w0_wcnt");
    xfer(1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF, 0, 32'd0, 1'b1, "w0_err_range");
    idle(1'b1, "end_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_wait_completer.md
# apb_wait_completer

APB4 completer (responder) that terminates transfers issued by the team's APB master. It holds a DEPTH-word register bank with byte strobes and inserts a fixed, parameterised number of wait states on every transfer. It reports PSLVERR for misaligned, out-of-range or read-only-violating accesses, and exposes a read-only count of committed writes. It plugs into the existing top-level in place of the basic slave, so the master's PREADY/PSLVERR handling can be exercised.

## Interface
- DATA, 32: data bus width; multiple of 8.
- ADDR, 32: address bus width.
- DEPTH, 16: number of read/write registers; power of two, at least 2.
- WAIT, 2: wait states per transfer, 0..15.
- pclk, input, 1: clock; all state changes on the rising edge.
- preset, input, 1: reset, asynchronous, active-high.
- paddr, input, ADDR: byte address.
- pwrite, input, 1: 1 = write, 0 = read.
- pwdata, input, DATA: write data.
- pstrb, input, DATA/8: write byte-lane enables; ignored on reads.
- psel, input, 1: completer select.
- penable, input, 1: access phase.
- prdata, output, DATA: read data; valid only while pready=1 on a read.
- pready, output, 1: transfer completes in this cycle.
- pslverr, output, 1: error response; valid only while pready=1.

## Operation
- Address map, word-aligned:
  - index = paddr[2 +: log2(DEPTH)]; registers occupy bytes 0 .. DEPTH*4-1.
  - Byte address DEPTH*4 is WCNT, read-only, 32-bit, reset 0.
- Error conditions, evaluated at the setup edge and latched:
  - paddr[1:0] != 0;
  - paddr > DEPTH*4;
  - a write to WCNT.
- Error transfers do not modify any state, and prdata = 0.
- Registered FSM, states IDLE, WAIT, READY:
  - IDLE: on psel=1 and penable=0, latch addr, pwrite, pwdata, pstrb and the error flag.
    - WAIT=0: go to READY; pready<=1, pslverr<=err, prdata<=read value (0 if write or err).
    - WAIT>0: go to WAIT with cnt<=WAIT-1.
  - WAIT, with psel=1:
    - cnt=0: go to READY, driving outputs as above.
    - otherwise: cnt<=cnt-1.
  - WAIT, with psel=0 (protocol abort): go to IDLE; no write; outputs stay 0.
  - READY, completion edge:
    - Commit the write if pwrite=1 and err=0; byte lane k updates only if pstrb[k]=1.
    - WCNT increments on every committed write, including pstrb=0; wraps 0xFFFFFFFF -> 0.
    - Clear pready, pslverr and prdata to 0; go to IDLE.
- Read data is sampled from the bank at the edge that enters READY, so a write completing earlier is visible.
- Reset clears all registers, WCNT, cnt and the outputs to 0 and sets the state to IDLE. A transfer in flight at reset is dropped, with no write.

## Timing
- Setup phase in cycle T; access phase from T+1.
- pready is low for exactly WAIT access cycles, then high for exactly one cycle (T+1+WAIT); the transfer ends at that cycle's closing edge.
- Write data is visible to a read whose setup phase is at or after the completion cycle + 1.
- Back-to-back transfers are supported: a setup in the cycle after pready is accepted with no idle gap.
- Outputs are registered; there is no combinational path from APB inputs to pready, prdata or pslverr.
- Reset values: pready=0, pslverr=0, prdata=0.

## Test plan
- Reset, then read addr 0x08 with WAIT=2: pready low in access cycles 1-2 and high in cycle 3; prdata=0, pslverr=0.
- Write 0xDEADBEEF to 0x04 with pstrb=4'b1111, then write 0x00000011 with pstrb=4'b0001, then read 0x04:
  - read returns 0xDEADBE11;
  - reading WCNT (0x40) returns 2.
- Error cases, each must give pslverr=1 with pready, and all registers and WCNT unchanged:
  - write to 0x06 (misaligned);
  - write to 0x44 (out of range);
  - write to 0x40 (WCNT);
  - read of 0x80 additionally returns prdata=0.
- Rebuild with WAIT=0: four back-to-back writes to 0x00-0x0C, then four reads:
  - pready is high in every access cycle;
  - the reads return the written values.
- preset asserted in the second wait cycle of a write of 0xA5A5A5A5 to 0x00:
  - outputs go to 0 immediately;
  - a later read of 0x00 returns 0.
- psel dropped mid-WAIT during a write: no write occurs, WCNT is unchanged, and the next transfer completes normally.
